// File: rtl/margin_scan_ctrl_if.sv
// Scan bus for margin_scan_ctrl: host start/stall/busy/done, score RAM read port,
// and the data-valid sideband consumed by the top-2/margin tracker.
`timescale 1ns/1ps
interface margin_scan_ctrl_if #(
  parameter int IDX_WIDTH = 16,
  parameter int CLS_WIDTH = 8
);
  logic                 start;
  logic                 stall;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [IDX_WIDTH-1:0] rd_sample;
  logic [CLS_WIDTH-1:0] rd_class;
  logic                 dv;
  logic                 d_first;
  logic                 d_last;
  logic [IDX_WIDTH-1:0] d_sample;

  // Handshake: rd_en is a strobe the RAM always accepts; stall is the only
  // back-pressure and only gates issue while scanning. dv/d_* carry no ready:
  // they arrive exactly RD_LAT cycles after the matching rd_en, unconditionally.
  modport master (
    input  start, stall,
    output busy, done, rd_en, rd_sample, rd_class,
    output dv, d_first, d_last, d_sample
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_en, rd_sample, rd_class,
    input  dv, d_first, d_last, d_sample
  );
endinterface

// File: rtl/margin_scan_ctrl.sv
// Sample-major (sample, class) read sequencer with an RD_LAT-aligned sideband.
// Optional feature macro: MS_SCAN_ABORT_EN adds the abort port.
`timescale 1ns/1ps
module margin_scan_ctrl #(
  parameter int N_SAMPLES = 512,
  parameter int N_CLASSES = 10,
  parameter int IDX_WIDTH = 16,
  parameter int CLS_WIDTH = 8,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MS_SCAN_ABORT_EN
  input  logic                 abort,
`endif
  margin_scan_ctrl_if.master   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_SMP   = IDX_WIDTH'(N_SAMPLES - 1);
  localparam logic [CLS_WIDTH-1:0] LAST_CLS   = CLS_WIDTH'(N_CLASSES - 1);
  localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(RD_LAT - 1);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] sample_q;
  logic [CLS_WIDTH-1:0] class_q;
  logic [DRAIN_W-1:0]   drain_q;

  logic                 abort_hit;
  logic                 issue;
  logic                 last_cls;
  logic                 last_smp;

  logic [RD_LAT-1:0]    pv_q;
  logic [RD_LAT-1:0]    pf_q;
  logic [RD_LAT-1:0]    pl_q;
  logic [IDX_WIDTH-1:0] ps_q [RD_LAT];

`ifdef MS_SCAN_ABORT_EN
  // Abort only matters while reads are in flight; IDLE and DONE ignore it.
  assign abort_hit = abort && ((state_q == S_SCAN) || (state_q == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign last_cls = (class_q == LAST_CLS);
  assign last_smp = (sample_q == LAST_SMP);
  assign issue    = (state_q == S_SCAN) && !bus.stall && !abort_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (abort_hit)                         state_d = S_IDLE;
        else if (issue && last_cls && last_smp) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_hit)                  state_d = S_IDLE;
        else if (drain_q == LAST_DRAIN) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters advance only on an actual issue; wrap of the last pair returns both to 0.
  always_ff @(posedge clk) begin
    if (!rst_n || abort_hit) begin
      sample_q <= '0;
      class_q  <= '0;
    end else if (issue) begin
      if (last_cls) begin
        class_q  <= '0;
        sample_q <= last_smp ? '0 : sample_q + IDX_WIDTH'(1);
      end else begin
        class_q  <= class_q + CLS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (state_q != S_DRAIN)) begin
      drain_q <= '0;
    end else begin
      drain_q <= drain_q + DRAIN_W'(1);
    end
  end

  // Sideband shifts every cycle: the RAM latency is fixed, so stall never holds it.
  always_ff @(posedge clk) begin
    if (!rst_n || abort_hit) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
      for (int i = 0; i < RD_LAT; i++) ps_q[i] <= '0;
    end else begin
      pv_q[0] <= issue;
      pf_q[0] <= issue && (class_q == '0);
      pl_q[0] <= issue && last_cls;
      ps_q[0] <= issue ? sample_q : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
        ps_q[i] <= ps_q[i-1];
      end
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_sample = sample_q;
  assign bus.rd_class  = class_q;
  assign bus.dv        = pv_q[RD_LAT-1];
  assign bus.d_first   = pf_q[RD_LAT-1];
  assign bus.d_last    = pl_q[RD_LAT-1];
  assign bus.d_sample  = ps_q[RD_LAT-1];
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_margin_scan_ctrl.sv
// Directed bench for margin_scan_ctrl: small 4x3 instance with table and
// corner-case sequences, plus a default-parameter instance for the full scan.
`timescale 1ns/1ps
module tb_margin_scan_ctrl;

  localparam int NS  = 4;
  localparam int NC  = 3;
  localparam int LAT = 2;
  localparam int NN  = NS * NC;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [15:0] rs;
    logic [7:0]  rc;
    logic        dv;
    logic        df;
    logic        dl;
    logic [15:0] ds;
  } out_t;

  typedef struct {
    logic start;
    logic stall;
    out_t exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_s;
  logic [1:0] dbg_b;
  int         total;
  int         bad;
  vec_t       tbl[17];

  margin_scan_ctrl_if #(.IDX_WIDTH(16), .CLS_WIDTH(8)) bs ();
  margin_scan_ctrl_if #(.IDX_WIDTH(16), .CLS_WIDTH(8)) bb ();

`ifdef MS_SCAN_ABORT_EN
  logic abort;
`endif

  margin_scan_ctrl #(
    .N_SAMPLES(NS), .N_CLASSES(NC), .IDX_WIDTH(16), .CLS_WIDTH(8), .RD_LAT(LAT)
  ) u_small (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MS_SCAN_ABORT_EN
    .abort(abort),
`endif
    .bus(bs),
    .dbg_state(dbg_s)
  );

  margin_scan_ctrl u_big (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MS_SCAN_ABORT_EN
    .abort(1'b0),
`endif
    .bus(bb),
    .dbg_state(dbg_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t mk(int busy, int done, int rd_en, int rs, int rc,
                              int dv, int df, int dl, int ds);
    out_t o;
    o.busy = busy[0]; o.done = done[0]; o.rd_en = rd_en[0];
    o.rs = 16'(rs); o.rc = 8'(rc);
    o.dv = dv[0]; o.df = df[0]; o.dl = dl[0]; o.ds = 16'(ds);
    return o;
  endfunction

  function automatic out_t get_small();
    out_t o;
    o.busy = bs.busy; o.done = bs.done; o.rd_en = bs.rd_en;
    o.rs = bs.rd_sample; o.rc = bs.rd_class;
    o.dv = bs.dv; o.df = bs.d_first; o.dl = bs.d_last; o.ds = bs.d_sample;
    return o;
  endfunction

  // scoreboard
  task automatic check_out(string name, int c, out_t act, out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Timing model for one scan started in relative cycle 0; sm marks stalled cycles.
  function automatic int issued_before(int x, logic [63:0] sm);
    int k = 0;
    for (int y = 1; y < x; y++) if (k < NN && !sm[y]) k++;
    return k;
  endfunction

  function automatic bit rd_en_at(int x, logic [63:0] sm);
    if (x < 1) return 1'b0;
    return (issued_before(x, sm) < NN) && !sm[x];
  endfunction

  function automatic int done_cycle(logic [63:0] sm);
    for (int x = 1; x < 64; x++)
      if (rd_en_at(x, sm) && issued_before(x, sm) == NN - 1) return x + LAT + 1;
    return -1;
  endfunction

  function automatic out_t exp_at(int c, logic [63:0] sm);
    out_t o = '0;
    int   j;
    int   dc = done_cycle(sm);
    o.busy = (c >= 1) && (c <= dc);
    o.done = (c == dc);
    if (c >= 1 && issued_before(c, sm) < NN) begin
      j = issued_before(c, sm);
      o.rd_en = !sm[c];
      o.rs = 16'(j / NC);
      o.rc = 8'(j % NC);
    end
    if (rd_en_at(c - LAT, sm)) begin
      j = issued_before(c - LAT, sm);
      o.dv = 1'b1;
      o.df = (j % NC) == 0;
      o.dl = (j % NC) == NC - 1;
      o.ds = 16'(j / NC);
    end
    return o;
  endfunction

  initial begin
    logic [63:0] sm;
    int n_rd, n_f, n_l, n_done, last_dv, done_c, first_rd, last_ds;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bs.start = 1'b0; bs.stall = 1'b0;
    bb.start = 1'b0; bb.stall = 1'b0;
`ifdef MS_SCAN_ABORT_EN
    abort = 1'b0;
`endif

    // Basic scan, hand-computed per cycle: cycle, start, stall, expected outputs.
    tbl[0]  = '{1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,0)};
    tbl[2]  = '{1'b0, 1'b0, mk(1,0,1,0,1,0,0,0,0)};
    tbl[3]  = '{1'b0, 1'b0, mk(1,0,1,0,2,1,1,0,0)};
    tbl[4]  = '{1'b0, 1'b0, mk(1,0,1,1,0,1,0,0,0)};
    tbl[5]  = '{1'b0, 1'b0, mk(1,0,1,1,1,1,0,1,0)};
    tbl[6]  = '{1'b0, 1'b0, mk(1,0,1,1,2,1,1,0,1)};
    tbl[7]  = '{1'b0, 1'b0, mk(1,0,1,2,0,1,0,0,1)};
    tbl[8]  = '{1'b0, 1'b0, mk(1,0,1,2,1,1,0,1,1)};
    tbl[9]  = '{1'b0, 1'b0, mk(1,0,1,2,2,1,1,0,2)};
    tbl[10] = '{1'b0, 1'b0, mk(1,0,1,3,0,1,0,0,2)};
    tbl[11] = '{1'b0, 1'b0, mk(1,0,1,3,1,1,0,1,2)};
    tbl[12] = '{1'b0, 1'b0, mk(1,0,1,3,2,1,1,0,3)};
    tbl[13] = '{1'b0, 1'b0, mk(1,0,0,0,0,1,0,0,3)};
    tbl[14] = '{1'b0, 1'b0, mk(1,0,0,0,0,1,0,1,3)};
    tbl[15] = '{1'b0, 1'b0, mk(1,1,0,0,0,0,0,0,0)};
    tbl[16] = '{1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0)};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_out("reset_small", 0, get_small(), '0);
    check_int("reset_state", int'(dbg_s), 0);
    check_int("reset_big_busy", int'(bb.busy), 0);
    rst_n = 1'b1;
    tick();

    // Basic table
    for (int c = 0; c < 17; c++) begin
      bs.start = tbl[c].start;
      bs.stall = tbl[c].stall;
      @(negedge clk);
      check_out("basic", c, get_small(), tbl[c].exp);
      tick();
    end

    // Stall in cycles 2..4 inside SCAN, plus stall in IDLE and DRAIN/DONE (no effect)
    sm = '0;
    sm[0] = 1'b1;
    for (int i = 2; i <= 4; i++) sm[i] = 1'b1;
    for (int i = 16; i <= 19; i++) sm[i] = 1'b1;
    for (int c = 0; c < 21; c++) begin
      bs.start = (c == 0);
      bs.stall = sm[c];
      @(negedge clk);
      check_out("stall", c, get_small(), exp_at(c, sm));
      if (c == 18) check_int("stall_done18", int'(bs.done), 1);
      tick();
    end
    bs.stall = 1'b0;

    // start held through the scan and its done cycle, dropped after cycle 16
    sm = '0;
    for (int c = 0; c <= 32; c++) begin
      bs.start = (c <= 16);
      @(negedge clk);
      if (c <= 16) check_out("hold", c, get_small(), exp_at(c, sm));
      else         check_out("hold_restart", c, get_small(), exp_at(c - 16, sm));
      tick();
    end
    bs.start = 1'b0;

    // Reset in cycle 6, then restart from (0,0) in cycle 13
    for (int c = 0; c <= 29; c++) begin
      bs.start = (c == 0) || (c == 13);
      rst_n    = (c != 6);
      @(negedge clk);
      if (c <= 6)       check_out("rst_pre", c, get_small(), exp_at(c, sm));
      else if (c <= 12) check_out("rst_flush", c, get_small(), '0);
      else              check_out("rst_restart", c, get_small(), exp_at(c - 13, sm));
      tick();
    end
    rst_n = 1'b1;
    bs.start = 1'b0;

`ifdef MS_SCAN_ABORT_EN
    // Abort in cycle 7: idle and no data from cycle 8, no done
    for (int c = 0; c <= 17; c++) begin
      bs.start = (c == 0);
      abort    = (c == 7);
      @(negedge clk);
      if (c <= 6)      check_out("abort_pre", c, get_small(), exp_at(c, sm));
      else if (c >= 8) check_out("abort_post", c, get_small(), '0);
      tick();
    end
    abort = 1'b0;
`endif

    // Default-parameter full scan
    n_rd = 0; n_f = 0; n_l = 0; n_done = 0;
    last_dv = -1; done_c = -1; first_rd = -1; last_ds = -1;
    for (int c = 0; c <= 5130; c++) begin
      bb.start = (c == 0);
      @(negedge clk);
      if (bb.rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = c;
      end
      if (bb.dv) begin
        last_dv = c;
        if (bb.d_first) n_f++;
        if (bb.d_last) begin
          n_l++;
          last_ds = int'(bb.d_sample);
        end
      end
      if (bb.done) begin
        n_done++;
        done_c = c;
      end
      tick();
    end
    check_int("big_rd_count", n_rd, 5120);
    check_int("big_first_rd", first_rd, 1);
    check_int("big_last_dv", last_dv, 5122);
    check_int("big_done_cyc", done_c, 5123);
    check_int("big_done_cnt", n_done, 1);
    check_int("big_first_cnt", n_f, 512);
    check_int("big_last_cnt", n_l, 512);
    check_int("big_last_sample", last_ds, 511);
    @(negedge clk);
    check_int("big_idle_end", int'(bb.busy), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/margin_scan_ctrl.md
# margin_scan_ctrl

Sequencer for the margin-sampling datapath. On `start` it walks every (sample, class) pair of the score memory in sample-major order, with class as the inner loop. It issues one read per cycle and delivers a valid/first/last/sample-index sideband aligned to the memory's fixed read latency, so the downstream top-2/margin tracker can consume scores without its own counters. It sits between the host control register (`start`/`done`) and the score RAM read port plus margin datapath.

## Interface
Parameters:
- `N_SAMPLES`, 512, samples per scan (≥1).
- `N_CLASSES`, 10, classes per sample (≥2).
- `IDX_WIDTH`, 16, sample-index width; N_SAMPLES ≤ 2^IDX_WIDTH.
- `CLS_WIDTH`, 8, class-index width; N_CLASSES ≤ 2^CLS_WIDTH.
- `RD_LAT`, 2, score RAM read latency in cycles (≥1).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  level-sampled scan request; honoured only in IDLE.
- `stall`  in  1  downstream/RAM not ready; suppresses issue in SCAN.
- `abort`  in  1  cancel scan (present only with `MS_SCAN_ABORT_EN`).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at scan completion.
- `rd_en`  out  1  RAM read strobe.
- `rd_sample`  out  IDX_WIDTH  read sample index.
- `rd_class`  out  CLS_WIDTH  read class index.
- `dv`  out  1  RAM data valid, exactly RD_LAT cycles after `rd_en`.
- `d_first`  out  1  with `dv`: data is class 0 of its sample.
- `d_last`  out  1  with `dv`: data is class N_CLASSES-1 of its sample.
- `d_sample`  out  IDX_WIDTH  sample index of the data under `dv`.

## Operation
FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: counters at 0. `start`=1 moves to SCAN.
- SCAN: `rd_en` = !stall, combinational from the state register and `stall`.
  - Each cycle with `rd_en`=1 issues the current (`rd_sample`, `rd_class`) and then advances the counters.
  - `rd_class` wraps from N_CLASSES-1 to 0 and increments `rd_sample`.
  - Issuing (N_SAMPLES-1, N_CLASSES-1) moves to DRAIN. The counters return to 0.
- DRAIN: no issue. Stays for exactly RD_LAT cycles so the last read emerges, then moves to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Sideband pipeline: an RD_LAT-deep shift register carries {valid, first, last, sample} from the issue point.
  - It shifts every cycle regardless of `stall`, because the RAM latency is fixed.
  - Outputs `dv`, `d_first`, `d_last`, `d_sample` are the pipeline tail.
- `start` while busy, including the DONE cycle, is ignored and not queued.
- `stall` outside SCAN has no effect.
- Counter arithmetic is unsigned. Each counter is compared against its parameter-1 bound, so no counter ever exceeds that bound.

## Timing
- Reset: state IDLE, counters 0, pipeline cleared. Outputs `busy`, `done`, `rd_en`, `dv`, `d_first`, `d_last` are 0; `rd_sample`, `rd_class`, `d_sample` are 0.
- With `start` high in cycle 0 and no stall, N = N_SAMPLES·N_CLASSES:
  - `busy` is high in cycles 1..N+RD_LAT+1.
  - `rd_en` is high in cycles 1..N.
  - `dv` is high in cycles 1+RD_LAT..N+RD_LAT.
  - `done` is high in cycle N+RD_LAT+1.
  - State is IDLE in cycle N+RD_LAT+2, where a new `start` is accepted.
- Each stalled SCAN cycle delays every later event by one cycle.
- Reset mid-scan: IDLE next cycle and the pipeline is flushed. No `dv` or `done` follows.

## Configuration
- `MS_SCAN_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in SCAN or DRAIN forces IDLE next cycle, clears the counters and pipeline valid bits, and suppresses `done`.
  - `abort` has priority over `stall`.
  - `abort` in IDLE or DONE is ignored.
- Undefined: no `abort` port. A scan always runs to `done` unless reset.

## Test plan
- Basic, with N_SAMPLES=4, N_CLASSES=3, RD_LAT=2; `start` in cycle 0:
  - `rd_en` cycles 1..12 issue (0,0),(0,1),(0,2),(1,0)…(3,2).
  - `dv` cycles 3..14; `d_first` at 3,6,9,12; `d_last` at 5,8,11,14; `d_sample` 0,0,0,1,…,3.
  - `done` only in cycle 15; `busy` high in cycles 1..15.
- Stall, same parameters: `stall` high in cycles 2..4 gives `rd_en`=0 there, with (0,1) issued in cycle 5. `dv` has a 3-cycle gap, and `done` lands in cycle 18.
- Start handling:
  - `start` held high during a scan starts no second scan.
  - `start` in the `done` cycle (15) is ignored.
  - `start` in cycle 16 begins a new scan with `rd_en` in cycle 17 at (0,0).
- Reset mid-scan: `rst_n`=0 in cycle 6 gives all outputs at reset values from cycle 7. No further `dv` and no `done`. A later `start` restarts at (0,0).
- Abort, with `MS_SCAN_ABORT_EN` defined: `abort` in cycle 7 gives `busy`=0 from cycle 8, `dv`=0 from cycle 8, and no `done`. With the macro undefined, the same stimulus minus `abort` completes with `done` in cycle 15.
- Default parameters: `start` in cycle 0 gives 5120 `rd_en` cycles, the last `dv` in cycle 5122, and `done` in cycle 5123.
